bcd_time_keeper: RTL and testbench
==================================

# bcd_time_keeper

Real-time BCD clock stage directly downstream of the switch/push-button control stage. Takes the 24-bit hh:mm:ss value assembled from the toggle switches, loads it on command, and counts it in 12-hour format once per second while running. It also raises a one-cycle alarm pulse when the running time reaches a programmed dose time, and feeds the seven-segment display and dispensing logic.

## Interface
- CLK_HZ, 50_000_000, clk cycles per second tick; must be ≥ 2.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- setTime  in  24  BCD {hT,hO,mT,mO,sT,sO}, 4 bits per digit, MSB = hour tens.
- loadTime  in  1  level; copy the sanitised setTime into currentTime while stopped.
- startPulse  in  1  one-cycle pulse; enter RUNNING.
- stopPulse  in  1  one-cycle pulse; enter STOPPED.
- alarmTime  in  24  BCD dose time, same digit layout as setTime.
- currentTime  out  24  registered BCD time.
- running  out  1  high in RUNNING.
- secondTick  out  1  one-cycle pulse on every seconds increment.
- alarmHit  out  1  one-cycle pulse when a tick makes currentTime equal alarmTime.

## Operation
- States: STOPPED (reset state), RUNNING.
- STOPPED: the prescaler holds. If loadTime=1, currentTime <= sanitise(setTime) and the prescaler clears to 0. startPulse moves to RUNNING.
- RUNNING: loadTime is ignored. The prescaler counts 0..CLK_HZ-1. At terminal count it wraps to 0, secondTick=1, and currentTime <= next(currentTime). stopPulse moves to STOPPED with the prescaler retained, so resuming continues the partial second.
- Sanitise, per digit, applied on load only:
  - hT > 1 → 1; hO > 9 → 9; if the hour is > 12 → 12; hour 00 → 12.
  - mT, sT > 5 → 5; mO, sO > 9 → 9.
- next():
  - sO 9→0 carries into sT; sT 5→0 carries into mO; mO 9→0 carries into mT; mT 5→0 carries into the hour.
  - Hour increment: 09→10, 12→01, otherwise BCD +1.
  - 12:59:59 → 01:00:00.
- alarmHit is registered on the same edge as the tick increment: alarmHit <= tick && (next(currentTime) == alarmTime). It never fires from a load or while stopped. alarmTime is compared raw, not sanitised.
- Simultaneous events:
  - startPulse + stopPulse in the same cycle: stop wins.
  - loadTime + startPulse while STOPPED: the load applies and the state becomes RUNNING on the same edge; the prescaler starts from 0.
  - stopPulse in the same cycle as terminal count: that tick still happens, then STOPPED.

## Timing
- Reset values:
  - currentTime = 24'h120000
  - running = 0
  - secondTick = 0
  - alarmHit = 0
  - prescaler = 0
  - state = STOPPED
- Reset mid-operation: the outputs above are forced asynchronously in the same cycle, with no pending tick or alarm afterwards.
- Load latency: 1 cycle. currentTime is valid on the edge after loadTime is sampled high.
- running rises/falls 1 cycle after startPulse/stopPulse.
- First tick after start from prescaler 0: exactly CLK_HZ cycles after the start edge. Subsequent ticks every CLK_HZ cycles.
- secondTick and alarmHit are single-cycle, aligned with the edge that updates currentTime.
- Prescaler width: clog2(CLK_HZ) bits, with no overflow for any legal CLK_HZ.

## Structure
- Shared package time_keeper_pkg holds:
  - DIGIT_W = 4
  - RESET_TIME = 24'h120000
  - HOUR_MAX = 12
  - the state enum {STOPPED, RUNNING}
  - the digit-slice index constants
- Sub-module bcd_time_next is combinational: 24-bit in → 24-bit next time plus a carry-out flag. It is reused by the seven-segment preview and unit-tested alone.
- The top level holds the prescaler, state register, sanitise logic and output registers.

## Test plan
Bench uses CLK_HZ=4.
- Reset asserted mid-count at 05:17:33 → currentTime=12:00:00, running=0, no secondTick or alarmHit afterwards.
- Stopped, setTime=12:59:58, loadTime + start, 8 cycles → 12:59:59 then 01:00:00, two secondTick pulses 4 cycles apart.
- Load setTime=24'h195979 → currentTime=12:59:59; load setTime=24'h000000 → currentTime=12:00:00.
- alarmTime=10:00:00, load 09:59:59, start → after 4 cycles currentTime=10:00:00 with alarmHit high exactly that cycle. Reloading 10:00:00 while stopped → no alarmHit.
- Running at 03:00:00: stopPulse after 2 prescaler cycles, hold 10 cycles, startPulse → next tick 2 cycles after restart. loadTime=1 while running leaves the time unchanged.
- startPulse and stopPulse in the same cycle from RUNNING → running=0. From STOPPED → stays stopped.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared constants, BCD digit layout and controller state encoding for the
// 12-hour BCD time keeper and its helpers.
package time_keeper_pkg;

  localparam int          DIGIT_W    = 4;
  localparam logic [23:0] RESET_TIME = 24'h120000;
  localparam int          HOUR_MAX   = 12;

  // Bit offset of each BCD digit in the packed {hT,hO,mT,mO,sT,sO} word
  localparam int SO_LSB = 0;
  localparam int ST_LSB = 4;
  localparam int MO_LSB = 8;
  localparam int MT_LSB = 12;
  localparam int HO_LSB = 16;
  localparam int HT_LSB = 20;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_time_next.sv
// Combinational 12-hour BCD successor: hh:mm:ss + 1 second.
// carry flags the 12:59:59 -> 01:00:00 wrap.
module bcd_time_next
  import time_keeper_pkg::*;
(
  input  logic [23:0] cur_bcd,
  output logic [23:0] nxt_bcd,
  output logic        carry
);

  logic [DIGIT_W-1:0] ht, ho, mt, mo, st, so;
  logic [DIGIT_W-1:0] n_ht, n_ho, n_mt, n_mo, n_st, n_so;

  assign ht = cur_bcd[HT_LSB +: DIGIT_W];
  assign ho = cur_bcd[HO_LSB +: DIGIT_W];
  assign mt = cur_bcd[MT_LSB +: DIGIT_W];
  assign mo = cur_bcd[MO_LSB +: DIGIT_W];
  assign st = cur_bcd[ST_LSB +: DIGIT_W];
  assign so = cur_bcd[SO_LSB +: DIGIT_W];

  always_comb begin
    n_ht  = ht;
    n_ho  = ho;
    n_mt  = mt;
    n_mo  = mo;
    n_st  = st;
    n_so  = so;
    carry = 1'b0;
    if (so != 4'd9) begin
      n_so = so + 4'd1;
    end else begin
      n_so = 4'd0;
      if (st != 4'd5) begin
        n_st = st + 4'd1;
      end else begin
        n_st = 4'd0;
        if (mo != 4'd9) begin
          n_mo = mo + 4'd1;
        end else begin
          n_mo = 4'd0;
          if (mt != 4'd5) begin
            n_mt = mt + 4'd1;
          end else begin
            n_mt = 4'd0;
            // Hour rolls 12 -> 01; 09 -> 10 falls out of the BCD ones carry
            if (ht == 4'd1 && ho == 4'd2) begin
              n_ht  = 4'd0;
              n_ho  = 4'd1;
              carry = 1'b1;
            end else if (ho == 4'd9) begin
              n_ht = ht + 4'd1;
              n_ho = 4'd0;
            end else begin
              n_ho = ho + 4'd1;
            end
          end
        end
      end
    end
  end

  assign nxt_bcd = {n_ht, n_ho, n_mt, n_mo, n_st, n_so};

endmodule

// File: rtl/bcd_time_keeper.sv
// 12-hour BCD real-time clock: load from switches while stopped, count one
// second per CLK_HZ cycles while running, pulse on reaching the dose time.
module bcd_time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] setTime,
  input  logic        loadTime,
  input  logic        startPulse,
  input  logic        stopPulse,
  input  logic [23:0] alarmTime,
  output logic [23:0] currentTime,
  output logic        running,
  output logic        secondTick,
  output logic        alarmHit
);

  localparam int                 PRESC_W  = $clog2(CLK_HZ);
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);

  state_t             state, state_next;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [23:0]        next_bcd;
  logic               unused_carry;

  // Clamp each switch digit into a legal 12-hour time; out-of-range hours become 12
  function automatic logic [23:0] sanitise(input logic [23:0] raw);
    logic [DIGIT_W-1:0] ht, ho, mt, mo, st, so;
    int hour;
    ht = raw[HT_LSB +: DIGIT_W];
    ho = raw[HO_LSB +: DIGIT_W];
    mt = raw[MT_LSB +: DIGIT_W];
    mo = raw[MO_LSB +: DIGIT_W];
    st = raw[ST_LSB +: DIGIT_W];
    so = raw[SO_LSB +: DIGIT_W];
    if (ht > 4'd1) ht = 4'd1;
    if (ho > 4'd9) ho = 4'd9;
    hour = 10 * int'(ht) + int'(ho);
    if (hour > HOUR_MAX || hour == 0) begin
      ht = 4'd1;
      ho = 4'd2;
    end
    if (mt > 4'd5) mt = 4'd5;
    if (mo > 4'd9) mo = 4'd9;
    if (st > 4'd5) st = 4'd5;
    if (so > 4'd9) so = 4'd9;
    return {ht, ho, mt, mo, st, so};
  endfunction

  bcd_time_next u_next (
    .cur_bcd (currentTime),
    .nxt_bcd (next_bcd),
    .carry   (unused_carry)
  );

  assign tick    = (state == RUNNING) && (presc == PRESC_TC);
  assign running = (state == RUNNING);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STOPPED;
    end else begin
      state <= state_next;
    end
  end

  // Stop dominates start in either state
  always_comb begin
    state_next = state;
    case (state)
      STOPPED: if (startPulse && !stopPulse) state_next = RUNNING;
      RUNNING: if (stopPulse)                state_next = STOPPED;
      default: state_next = STOPPED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      currentTime <= RESET_TIME;
      secondTick  <= 1'b0;
      alarmHit    <= 1'b0;
    end else begin
      secondTick <= tick;
      alarmHit   <= tick && (next_bcd == alarmTime);
      if (state == RUNNING) begin
        // Prescaler keeps counting on the stop edge, so a partial second resumes
        if (tick) begin
          presc       <= '0;
          currentTime <= next_bcd;
        end else begin
          presc <= presc + 1'b1;
        end
      end else if (loadTime) begin
        presc       <= '0;
        currentTime <= sanitise(setTime);
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed bench for bcd_time_keeper at CLK_HZ=4; every second tick is
// matched against a queue of expected (cycle, time, alarm) entries.
module tb_bcd_time_keeper;

  localparam int CLK_HZ = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] setTime;
  logic        loadTime;
  logic        startPulse;
  logic        stopPulse;
  logic [23:0] alarmTime;
  logic [23:0] currentTime;
  logic        running;
  logic        secondTick;
  logic        alarmHit;

  typedef struct packed {
    logic [31:0] cyc;
    logic [23:0] t;
    logic        a;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cyc_n  = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bcd_time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .reset       (reset),
    .setTime     (setTime),
    .loadTime    (loadTime),
    .startPulse  (startPulse),
    .stopPulse   (stopPulse),
    .alarmTime   (alarmTime),
    .currentTime (currentTime),
    .running     (running),
    .secondTick  (secondTick),
    .alarmHit    (alarmHit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expect_tick(input logic [31:0] n, input logic [23:0] t, input logic a);
    exp_t e;
    e.cyc = cyc_n + n;
    e.t   = t;
    e.a   = a;
    sb.push_back(e);
  endtask

  // One clock; any tick/alarm output is matched against the scoreboard head
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (secondTick || alarmHit) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL tick_unexpected observed=%h expected=none cycle=%0d", currentTime, cyc_n);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tick_cycle", cyc_n, e.cyc);
        chk("tick_time", {8'd0, currentTime}, {8'd0, e.t});
        chk("tick_alarm", {31'd0, alarmHit}, {31'd0, e.a});
        chk("tick_pulse", {31'd0, secondTick}, 32'd1);
      end
    end else if (sb.size() != 0 && cyc_n >= sb[0].cyc) begin
      e = sb.pop_front();
      chk("tick_missing", {31'd0, secondTick}, 32'd1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    setTime    = 24'h0;
    alarmTime  = 24'h0;
    loadTime   = 1'b0;
    startPulse = 1'b0;
    stopPulse  = 1'b0;
    cyc();
    cyc();
    chk("rst_time", {8'd0, currentTime}, 32'h120000);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_tick", {31'd0, secondTick}, 32'd0);
    chk("rst_alarm", {31'd0, alarmHit}, 32'd0);
    reset = 1'b0;
    cyc();

    // Reset asserted mid-count at 05:17:33
    setTime  = 24'h051733;
    loadTime = 1'b1;
    cyc();
    chk("load_051733", {8'd0, currentTime}, 32'h051733);
    loadTime   = 1'b0;
    startPulse = 1'b1;
    cyc();
    startPulse = 1'b0;
    chk("start_running", {31'd0, running}, 32'd1);
    cyc();
    cyc();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_time", {8'd0, currentTime}, 32'h120000);
    chk("async_rst_running", {31'd0, running}, 32'd0);
    chk("async_rst_tick", {31'd0, secondTick}, 32'd0);
    cyc();
    reset = 1'b0;
    repeat (8) cyc();
    chk("post_rst_time", {8'd0, currentTime}, 32'h120000);
    chk("post_rst_running", {31'd0, running}, 32'd0);

    // Load + start together; 12:59:58 -> 12:59:59 -> 01:00:00
    setTime    = 24'h125958;
    loadTime   = 1'b1;
    startPulse = 1'b1;
    expect_tick(5, 24'h125959, 1'b0);
    expect_tick(9, 24'h010000, 1'b0);
    cyc();
    chk("ld_start_time", {8'd0, currentTime}, 32'h125958);
    chk("ld_start_running", {31'd0, running}, 32'd1);
    loadTime   = 1'b0;
    startPulse = 1'b0;
    repeat (8) cyc();
    chk("wrap_time", {8'd0, currentTime}, 32'h010000);
    stopPulse = 1'b1;
    cyc();
    stopPulse = 1'b0;
    chk("stop_running", {31'd0, running}, 32'd0);

    // Sanitise
    setTime  = 24'h195979;
    loadTime = 1'b1;
    cyc();
    chk("sanitise_195979", {8'd0, currentTime}, 32'h125959);
    setTime = 24'h000000;
    cyc();
    chk("sanitise_000000", {8'd0, currentTime}, 32'h120000);
    loadTime = 1'b0;

    // Alarm on tick, not on load
    alarmTime  = 24'h100000;
    setTime    = 24'h095959;
    loadTime   = 1'b1;
    startPulse = 1'b1;
    expect_tick(5, 24'h100000, 1'b1);
    cyc();
    loadTime   = 1'b0;
    startPulse = 1'b0;
    repeat (4) cyc();
    chk("alarm_time", {8'd0, currentTime}, 32'h100000);
    stopPulse = 1'b1;
    cyc();
    stopPulse = 1'b0;
    setTime   = 24'h100000;
    loadTime  = 1'b1;
    cyc();
    loadTime = 1'b0;
    chk("load_no_alarm", {31'd0, alarmHit}, 32'd0);
    cyc();

    // Pause keeps the partial second; load ignored while running
    setTime    = 24'h030000;
    loadTime   = 1'b1;
    startPulse = 1'b1;
    cyc();
    chk("load_030000", {8'd0, currentTime}, 32'h030000);
    loadTime   = 1'b0;
    startPulse = 1'b0;
    cyc();
    stopPulse = 1'b1;
    cyc();
    stopPulse = 1'b0;
    chk("pause_running", {31'd0, running}, 32'd0);
    repeat (10) cyc();
    chk("pause_time", {8'd0, currentTime}, 32'h030000);
    startPulse = 1'b1;
    expect_tick(3, 24'h030001, 1'b0);
    cyc();
    startPulse = 1'b0;
    chk("resume_running", {31'd0, running}, 32'd1);
    setTime  = 24'h111111;
    loadTime = 1'b1;
    repeat (3) cyc();
    chk("run_load_ignored", {8'd0, currentTime}, 32'h030001);
    loadTime = 1'b0;

    // Start and stop together: stop wins
    startPulse = 1'b1;
    stopPulse  = 1'b1;
    cyc();
    chk("both_from_running", {31'd0, running}, 32'd0);
    cyc();
    chk("both_held_running", {31'd0, running}, 32'd0);
    startPulse = 1'b0;
    stopPulse  = 1'b0;
    repeat (6) cyc();
    chk("both_stays_stopped", {31'd0, running}, 32'd0);

    // Stop on the terminal-count edge still ticks
    setTime    = 24'h010000;
    loadTime   = 1'b1;
    startPulse = 1'b1;
    expect_tick(5, 24'h010001, 1'b0);
    cyc();
    loadTime   = 1'b0;
    startPulse = 1'b0;
    repeat (3) cyc();
    stopPulse = 1'b1;
    cyc();
    stopPulse = 1'b0;
    chk("stop_at_tc_running", {31'd0, running}, 32'd0);
    repeat (6) cyc();
    chk("stop_at_tc_time", {8'd0, currentTime}, 32'h010001);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
